// File: rtl/seg_scan_capture.sv
// Seven-segment scan readback: de-glitches the multiplexed digit/segment drive,
// decodes each digit to a nibble and assembles complete frames.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int STALL_CYCLES  = 1048576,
    parameter bit SEL_ACT_LOW   = 1'b1,
    parameter bit SEG_ACT_LOW   = 1'b1
) (
    input  logic                    BrdClk,
    input  logic                    aReset_n,
    input  logic [NUM_DIGITS-1:0]   bDigitSel,
    input  logic [7:0]              bSegmentOutput,
    output logic [4*NUM_DIGITS-1:0] bFrameValue,
    output logic [NUM_DIGITS-1:0]   bFrameDp,
    output logic [NUM_DIGITS-1:0]   bBlankMask,
    output logic [NUM_DIGITS-1:0]   bErrMask,
    output logic                    bFrameValid,
    output logic                    bSelErr,
    output logic                    bScanStall
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

    // state  | meaning
    // IDLE   | no digit selected
    // SETTLE | selection/pattern changed, counting equal samples
    // HELD   | digit captured, waiting for the next change
    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
    state_t state;

    logic [NUM_DIGITS-1:0]   selNorm, sSel, pSel;
    logic [7:0]              segNorm, sSeg, pSeg;
    logic [CW-1:0]           cnt, nextCnt;
    logic [SW-1:0]           stallCnt;
    logic [NUM_DIGITS-1:0]   seen, seenNext;
    logic [4*NUM_DIGITS-1:0] shadowVal, mergedVal;
    logic [NUM_DIGITS-1:0]   shadowDp, shadowBlank, shadowErr;
    logic [NUM_DIGITS-1:0]   mergedDp, mergedBlank, mergedErr;
    logic                    sameS, selAny, selOneHot, capture, storeOne;
    logic [5:0]              decoded;

    function automatic logic [5:0] decodeSeg(input logic [6:0] s);
        logic [5:0] r;
        r = 6'b00_0000;
        case (s)
            7'h3F: r = 6'h00;
            7'h06: r = 6'h01;
            7'h5B: r = 6'h02;
            7'h4F: r = 6'h03;
            7'h66: r = 6'h04;
            7'h6D: r = 6'h05;
            7'h7D: r = 6'h06;
            7'h07: r = 6'h07;
            7'h7F: r = 6'h08;
            7'h6F: r = 6'h09;
            7'h77: r = 6'h0A;
            7'h7C: r = 6'h0B;
            7'h39: r = 6'h0C;
            7'h5E: r = 6'h0D;
            7'h79: r = 6'h0E;
            7'h71: r = 6'h0F;
            7'h00: r = 6'b01_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    assign selNorm = SEL_ACT_LOW ? ~bDigitSel : bDigitSel;
    assign segNorm = SEG_ACT_LOW ? ~bSegmentOutput : bSegmentOutput;

    always_comb begin
        sameS     = (sSel == pSel) && (sSeg == pSeg);
        selAny    = |sSel;
        selOneHot = $onehot(sSel);
        if (!sameS)
            nextCnt = '0;
        else if (cnt == CNT_MAX)
            nextCnt = cnt;
        else
            nextCnt = cnt + 1'b1;
        // nextCnt passes through CNT_CAP only once per dwell, so this fires once
        capture  = selAny && (nextCnt == CNT_CAP) && ((state != HELD) || !sameS);
        storeOne = capture && selOneHot;
        decoded  = decodeSeg(sSeg[6:0]);
        seenNext = seen | (storeOne ? sSel : '0);
        mergedVal   = shadowVal;
        mergedDp    = shadowDp;
        mergedBlank = shadowBlank;
        mergedErr   = shadowErr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (storeOne && sSel[i]) begin
                mergedVal[4*i +: 4] = decoded[3:0];
                mergedDp[i]         = sSeg[7];
                mergedBlank[i]      = decoded[4];
                mergedErr[i]        = decoded[5];
            end
        end
    end

    always_ff @(posedge BrdClk) begin
        if (!aReset_n) begin
            sSel        <= '0;
            sSeg        <= '0;
            pSel        <= '0;
            pSeg        <= '0;
            cnt         <= '0;
            stallCnt    <= '0;
            seen        <= '0;
            shadowVal   <= '0;
            shadowDp    <= '0;
            shadowBlank <= '0;
            shadowErr   <= '0;
            bFrameValue <= '0;
            bFrameDp    <= '0;
            bBlankMask  <= '0;
            bErrMask    <= '0;
            bFrameValid <= 1'b0;
            bSelErr     <= 1'b0;
            state       <= IDLE;
        end else begin
            sSel <= selNorm;
            sSeg <= segNorm;
            pSel <= sSel;
            pSeg <= sSeg;
            cnt  <= nextCnt;

            if (sSel != pSel)
                stallCnt <= '0;
            else if (stallCnt != STALL_MAX)
                stallCnt <= stallCnt + 1'b1;

            bSelErr     <= capture && !selOneHot;
            bFrameValid <= 1'b0;

            if (storeOne) begin
                shadowVal   <= mergedVal;
                shadowDp    <= mergedDp;
                shadowBlank <= mergedBlank;
                shadowErr   <= mergedErr;
                if (&seenNext) begin
                    bFrameValue <= mergedVal;
                    bFrameDp    <= mergedDp;
                    bBlankMask  <= mergedBlank;
                    bErrMask    <= mergedErr;
                    bFrameValid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seenNext;
                end
            end

            if (!selAny)
                state <= IDLE;
            else if (capture)
                state <= HELD;
            else if (!sameS || state == IDLE)
                state <= SETTLE;
        end
    end

    assign bScanStall = (stallCnt == STALL_MAX);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with active-low select and segment drive.
module tb_seg_scan_capture;

    logic        BrdClk = 1'b0;
    logic        aReset_n = 1'b0;
    logic [7:0]  bDigitSel = 8'hFF;
    logic [7:0]  bSegmentOutput = 8'hFF;
    logic [31:0] bFrameValue;
    logic [7:0]  bFrameDp, bBlankMask, bErrMask;
    logic        bFrameValid, bSelErr, bScanStall;

    int total = 0;
    int bad = 0;
    int validCnt = 0;
    int selErrCnt = 0;

    seg_scan_capture #(
        .NUM_DIGITS(8), .STABLE_CYCLES(4), .STALL_CYCLES(16),
        .SEL_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
    ) dut (
        .BrdClk(BrdClk), .aReset_n(aReset_n), .bDigitSel(bDigitSel),
        .bSegmentOutput(bSegmentOutput), .bFrameValue(bFrameValue),
        .bFrameDp(bFrameDp), .bBlankMask(bBlankMask), .bErrMask(bErrMask),
        .bFrameValid(bFrameValid), .bSelErr(bSelErr), .bScanStall(bScanStall)
    );

    always #5 BrdClk = ~BrdClk;

    always @(negedge BrdClk) begin
        if (bFrameValid === 1'b1) validCnt++;
        if (bSelErr === 1'b1) selErrCnt++;
    end

    function automatic logic [7:0] segOf(input logic [3:0] v);
        logic [7:0] r;
        case (v)
            4'h0: r = 8'h3F; 4'h1: r = 8'h06; 4'h2: r = 8'h5B; 4'h3: r = 8'h4F;
            4'h4: r = 8'h66; 4'h5: r = 8'h6D; 4'h6: r = 8'h7D; 4'h7: r = 8'h07;
            4'h8: r = 8'h7F; 4'h9: r = 8'h6F; 4'hA: r = 8'h77; 4'hB: r = 8'h7C;
            4'hC: r = 8'h39; 4'hD: r = 8'h5E; 4'hE: r = 8'h79; default: r = 8'h71;
        endcase
        return r;
    endfunction

    // sel and seg are given active-high; the board drive is inverted
    task automatic drive(input logic [7:0] sel, input logic [7:0] seg, input int cyc);
        bDigitSel      = ~sel;
        bSegmentOutput = ~seg;
        repeat (cyc) @(negedge BrdClk);
    endtask

    task automatic test_reset;
        aReset_n = 1'b0;
        drive(8'h00, 8'h00, 3);
        aReset_n = 1'b1;
        @(negedge BrdClk);
        total++; if (bFrameValue !== 32'h0) begin bad++; $display("FAIL reset_value got=%h exp=0", bFrameValue); end
        total++; if (bFrameDp !== 8'h0) begin bad++; $display("FAIL reset_dp got=%h exp=0", bFrameDp); end
        total++; if (bBlankMask !== 8'h0) begin bad++; $display("FAIL reset_blank got=%h exp=0", bBlankMask); end
        total++; if (bErrMask !== 8'h0) begin bad++; $display("FAIL reset_err got=%h exp=0", bErrMask); end
        total++; if (bFrameValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bFrameValid); end
        total++; if (bSelErr !== 1'b0) begin bad++; $display("FAIL reset_selerr got=%b exp=0", bSelErr); end
        total++; if (bScanStall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bScanStall); end
    endtask

    task automatic test_basic_frame;
        int v0 = validCnt;
        for (int k = 0; k < 8; k++) drive(8'(1 << k), segOf(4'(k)), 10);
        total++; if (validCnt - v0 !== 1) begin bad++; $display("FAIL basic_valid_count got=%0d exp=1", validCnt - v0); end
        total++; if (bFrameValue !== 32'h76543210) begin bad++; $display("FAIL basic_value got=%h exp=76543210", bFrameValue); end
        total++; if (bErrMask !== 8'h00) begin bad++; $display("FAIL basic_err got=%h exp=00", bErrMask); end
        total++; if (bBlankMask !== 8'h00) begin bad++; $display("FAIL basic_blank got=%h exp=00", bBlankMask); end
    endtask

    task automatic test_err_blank;
        int v0 = validCnt;
        for (int k = 0; k < 8; k++) begin
            if (k == 3)      drive(8'(1 << k), 8'h49, 10);
            else if (k == 5) drive(8'(1 << k), 8'h00, 10);
            else if (k == 1) drive(8'(1 << k), segOf(4'(k)) | 8'h80, 10);
            else             drive(8'(1 << k), segOf(4'(k)), 10);
        end
        total++; if (validCnt - v0 !== 1) begin bad++; $display("FAIL errblank_valid_count got=%0d exp=1", validCnt - v0); end
        total++; if (bErrMask !== 8'h08) begin bad++; $display("FAIL errblank_err got=%h exp=08", bErrMask); end
        total++; if (bBlankMask !== 8'h20) begin bad++; $display("FAIL errblank_blank got=%h exp=20", bBlankMask); end
        total++; if (bFrameValue !== 32'h76040210) begin bad++; $display("FAIL errblank_value got=%h exp=76040210", bFrameValue); end
        total++; if (bFrameDp !== 8'h02) begin bad++; $display("FAIL errblank_dp got=%h exp=02", bFrameDp); end
    endtask

    task automatic test_multi_select;
        int v0 = validCnt;
        int s0 = selErrCnt;
        drive(8'h03, segOf(4'h1), 10);
        drive(8'h00, 8'h00, 4);
        total++; if (selErrCnt - s0 !== 1) begin bad++; $display("FAIL multisel_selerr_count got=%0d exp=1", selErrCnt - s0); end
        total++; if (validCnt - v0 !== 0) begin bad++; $display("FAIL multisel_valid_count got=%0d exp=0", validCnt - v0); end
    endtask

    task automatic test_glitch_settle;
        int v0;
        int got = 0;
        for (int k = 0; k < 8; k++) if (k != 2) drive(8'(1 << k), segOf(4'(k)), 10);
        v0 = validCnt;
        for (int t = 0; t < 4; t++) drive(8'h04, segOf((t % 2) ? 4'h3 : 4'h2), 3);
        total++; if (validCnt - v0 !== 0) begin bad++; $display("FAIL glitch_no_frame got=%0d exp=0", validCnt - v0); end
        bDigitSel      = ~8'h04;
        bSegmentOutput = ~segOf(4'h9);
        for (int c = 1; c <= 10; c++) begin
            @(posedge BrdClk); #1;
            if (bFrameValid === 1'b1 && got == 0) got = c;
        end
        total++; if (got !== 5) begin bad++; $display("FAIL settle_latency got=%0d exp=5", got); end
        total++; if (bFrameValue !== 32'h76543910) begin bad++; $display("FAIL settle_value got=%h exp=76543910", bFrameValue); end
    endtask

    task automatic test_stall;
        drive(8'h01, segOf(4'h0), 10);
        total++; if (bScanStall !== 1'b0) begin bad++; $display("FAIL stall_early got=%b exp=0", bScanStall); end
        drive(8'h01, segOf(4'h0), 10);
        total++; if (bScanStall !== 1'b1) begin bad++; $display("FAIL stall_set got=%b exp=1", bScanStall); end
        drive(8'h02, segOf(4'h1), 2);
        total++; if (bScanStall !== 1'b0) begin bad++; $display("FAIL stall_clear got=%b exp=0", bScanStall); end
    endtask

    task automatic test_reset_midframe;
        int v0;
        for (int k = 0; k < 5; k++) drive(8'(1 << k), segOf(4'h5), 6);
        aReset_n = 1'b0;
        @(negedge BrdClk);
        aReset_n = 1'b1;
        total++; if (bFrameValue !== 32'h0) begin bad++; $display("FAIL midreset_value got=%h exp=0", bFrameValue); end
        total++; if (bFrameDp !== 8'h0) begin bad++; $display("FAIL midreset_dp got=%h exp=0", bFrameDp); end
        v0 = validCnt;
        for (int k = 5; k < 8; k++) drive(8'(1 << k), segOf(4'(15 - k)), 6);
        total++; if (validCnt - v0 !== 0) begin bad++; $display("FAIL midreset_partial got=%0d exp=0", validCnt - v0); end
        for (int k = 0; k < 5; k++) drive(8'(1 << k), segOf(4'(15 - k)), 6);
        total++; if (validCnt - v0 !== 1) begin bad++; $display("FAIL midreset_complete got=%0d exp=1", validCnt - v0); end
        total++; if (bFrameValue !== 32'h89ABCDEF) begin bad++; $display("FAIL midreset_value2 got=%h exp=89abcdef", bFrameValue); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_err_blank();
        test_multi_select();
        test_glitch_settle();
        test_stall();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
